// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier: FSM states, default width
// and radix-4 Booth digit codes packed as {neg, two, one}.
package mult_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [2:0] BoothZero = 3'b000;
  localparam logic [2:0] BoothPos1 = 3'b001;
  localparam logic [2:0] BoothPos2 = 3'b010;
  localparam logic [2:0] BoothNeg1 = 3'b101;
  localparam logic [2:0] BoothNeg2 = 3'b110;

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: maps {b[2i+1], b[2i], b[2i-1]} to a signed digit in {-2..+2}
// expressed as sign/magnitude flags for the partial-product mux.
module booth_r4_recoder
  import mult_pkg::*;
(
  input  logic [2:0] bits,
  output logic       neg,
  output logic       one,
  output logic       two
);

  logic [2:0] digit;

  always_comb begin
    digit = BoothZero;
    unique case (bits)
      3'b000, 3'b111: digit = BoothZero;
      3'b001, 3'b010: digit = BoothPos1;
      3'b011:         digit = BoothPos2;
      3'b100:         digit = BoothNeg2;
      3'b101, 3'b110: digit = BoothNeg1;
    endcase
  end

  assign {neg, two, one} = digit;

endmodule

// File: rtl/mult_seq_module.sv
// Sequential signed multiplier, radix-4 Booth, one digit per cycle over WIDTH/2 cycles.
// Returns the low WIDTH product bits and flags signed overflow; divider-style handshake.
module mult_seq_module
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_inputRDY,
  output logic             data_resultRDY
);

  localparam int unsigned ITER = WIDTH / 2;
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned AccW = WIDTH + 2;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [AccW-1:0]  mcand_q, mcand_d;
  logic [WIDTH:0]   low_q, low_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic             neg, one, two;
  logic [AccW-1:0]  mag, pp, sum, acc_sh;
  logic [WIDTH:0]   low_sh;
  logic             last_iter;

  // low_q[2:0] always holds the next Booth window since the pair shifts by 2 each cycle.
  booth_r4_recoder u_recoder (
    .bits (low_q[2:0]),
    .neg  (neg),
    .one  (one),
    .two  (two)
  );

  always_comb begin
    mag = '0;
    if (one) begin
      mag = mcand_q;
    end else if (two) begin
      mag = {mcand_q[AccW-2:0], 1'b0};
    end
    pp     = neg ? (~mag + AccW'(1)) : mag;
    sum    = acc_q + pp;
    acc_sh = {{2{sum[AccW-1]}}, sum[AccW-1:2]};
    low_sh = {sum[1:0], low_q[WIDTH:2]};
  end

  assign last_iter = (count_q == CntW'(ITER - 1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    low_d    = low_q;
    result_d = result_q;
    exc_d    = exc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (ctrl_MULT) begin
          mcand_d = {{2{data_operandA[WIDTH-1]}}, data_operandA};
          low_d   = {data_operandB, 1'b0};
          acc_d   = '0;
          count_d = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d   = acc_sh;
        low_d   = low_sh;
        count_d = count_q + CntW'(1);
        if (last_iter) begin
          state_d  = StDone;
          result_d = low_sh[WIDTH:1];
          // Overflow unless every bit from the result sign upward matches.
          exc_d    = !((&{acc_sh, low_sh[WIDTH]}) || !(|{acc_sh, low_sh[WIDTH]}));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      low_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      low_q    <= low_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_inputRDY  = (state_q != StBusy);
  assign data_resultRDY = (state_q == StDone);

endmodule

// File: tb/tb_mult_seq_module.sv
// Directed self-checking bench for mult_seq_module: vector table plus handshake corner cases.
module tb_mult_seq_module;

  logic        clock;
  logic        reset_n;
  logic [31:0] opa, opb;
  logic        ctrl;
  logic [31:0] result;
  logic        exc, in_rdy, res_rdy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[9];

  mult_seq_module #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .ctrl_MULT      (ctrl),
    .data_result    (result),
    .data_exception (exc),
    .data_inputRDY  (in_rdy),
    .data_resultRDY (res_rdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a start pulse on the next rising edge (E0); returns #1 after E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    opa  = a;
    opb  = b;
    ctrl = 1'b1;
    @(posedge clock);
    #1;
    ctrl = 1'b0;
  endtask

  // Count edges until resultRDY, bounded; also counts cycles where inputRDY was high while busy.
  task automatic wait_done(output int edges, output int rdy_bad);
    edges   = 0;
    rdy_bad = 0;
    while (!res_rdy && edges < 40) begin
      if (in_rdy !== 1'b0) rdy_bad++;
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  initial begin
    int edges, rdy_bad;

    vecs[0] = '{32'd3,         32'd5,         32'd15,        1'b0};
    vecs[1] = '{32'hFFFFFFF9,  32'd6,         32'hFFFFFFD6,  1'b0};
    vecs[2] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         1'b0};
    vecs[3] = '{32'h7FFFFFFF,  32'd2,         32'hFFFFFFFE,  1'b1};
    vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1};
    vecs[5] = '{32'h00010000,  32'h00008000,  32'h80000000,  1'b1};
    vecs[6] = '{32'hFFFF0000,  32'h00008000,  32'h80000000,  1'b0};
    vecs[7] = '{32'h80000000,  32'h80000000,  32'h00000000,  1'b1};
    vecs[8] = '{32'd0,         32'h12345678,  32'h00000000,  1'b0};

    reset_n = 1'b0;
    ctrl    = 1'b0;
    opa     = '0;
    opb     = '0;
    #12;
    chk("reset result", result, 32'd0);
    chk("reset exception", {31'd0, exc}, 32'd0);
    chk("reset resultRDY", {31'd0, res_rdy}, 32'd0);
    chk("reset inputRDY", {31'd0, in_rdy}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;

    // Result is due 16 edges after the start edge (17 edges counting the start edge).
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(edges, rdy_bad);
      chk($sformatf("vec%0d latency", i), edges, 32'd16);
      chk($sformatf("vec%0d inputRDY busy", i), rdy_bad, 32'd0);
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      chk($sformatf("vec%0d exception", i), {31'd0, exc}, {31'd0, vecs[i].exc});
    end

    // DONE holds its outputs while idle.
    repeat (3) @(posedge clock);
    #1;
    chk("hold resultRDY", {31'd0, res_rdy}, 32'd1);
    chk("hold result", result, 32'd0);

    // ctrl_MULT pulsed on E5 with new operands is ignored.
    start_op(32'd100, 32'd7);
    repeat (4) @(posedge clock);
    @(negedge clock);
    opa  = 32'd11;
    opb  = 32'd11;
    ctrl = 1'b1;
    @(posedge clock);
    #1;
    ctrl = 1'b0;
    wait_done(edges, rdy_bad);
    chk("ignored ctrl latency", edges, 32'd11);
    chk("ignored ctrl result", result, 32'd700);

    // Restart from DONE: old result held until the new completion.
    start_op(32'd2, 32'd2);
    chk("restart resultRDY falls", {31'd0, res_rdy}, 32'd0);
    chk("restart result held", result, 32'd700);
    repeat (8) @(posedge clock);
    #1;
    chk("restart result mid-busy", result, 32'd700);
    wait_done(edges, rdy_bad);
    chk("restart latency", edges, 32'd8);
    chk("restart result", result, 32'd4);

    // Asynchronous reset mid-busy aborts the operation.
    start_op(32'd123, 32'd456);
    repeat (6) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort result", result, 32'd0);
    chk("abort exception", {31'd0, exc}, 32'd0);
    chk("abort resultRDY", {31'd0, res_rdy}, 32'd0);
    chk("abort inputRDY", {31'd0, in_rdy}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    start_op(32'd9, 32'd9);
    wait_done(edges, rdy_bad);
    chk("post-reset latency", edges, 32'd16);
    chk("post-reset result", result, 32'd81);
    chk("post-reset exception", {31'd0, exc}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
